// File: rtl/matmul_tile_engine.sv
// Output-stationary TILE_M x TILE_N matrix-multiply engine: loads A and B over AXI-Stream,
// accumulates one k-step per cycle across all MACs, then streams C out in row-major order.
module matmul_tile_engine #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int TILE_M = 2,
    parameter int TILE_N = 2,
    parameter int K_MAX  = 8,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic              s_axis_a_tlast,
    input  logic [DATA_W-1:0] s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    input  logic              s_axis_b_tlast,
    output logic [ACC_W-1:0]  m_axis_c_tdata,
    output logic              m_axis_c_tvalid,
    input  logic              m_axis_c_tready,
    output logic              m_axis_c_tlast,
    input  logic [KW-1:0]     cfg_k,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int KI = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int MW = (TILE_M > 1) ? $clog2(TILE_M) : 1;
    localparam int NW = (TILE_N > 1) ? $clog2(TILE_N) : 1;
    localparam int PW = (2 * DATA_W > ACC_W) ? 2 * DATA_W : ACC_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        OUTPUT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [KW-1:0] k;
    logic [KW-1:0] k_last;
    logic [MW-1:0] a_row;
    logic [KW-1:0] a_col;
    logic [KW-1:0] b_row;
    logic [NW-1:0] b_col;
    logic [KW-1:0] j;
    logic [MW-1:0] c_row;
    logic [NW-1:0] c_col;
    logic          err_q;

    logic signed [DATA_W-1:0] a_buf [TILE_M][K_MAX];
    logic signed [DATA_W-1:0] b_buf [K_MAX][TILE_N];
    logic        [ACC_W-1:0]  acc   [TILE_M][TILE_N];

    logic          k_bad;
    logic          a_final;
    logic          b_final;
    logic          comp_last;
    logic          c_final;
    logic [KI-1:0] a_col_i;
    logic [KI-1:0] b_row_i;
    logic [KI-1:0] j_i;

    // Full signed product, reduced modulo 2^ACC_W (sign-extends when ACC_W is the wider side).
    function automatic logic [ACC_W-1:0] mac_term(input logic signed [DATA_W-1:0] x,
                                                  input logic signed [DATA_W-1:0] y);
        logic signed [PW-1:0] px;
        logic signed [PW-1:0] py;
        logic signed [PW-1:0] p;
        px = PW'(x);
        py = PW'(y);
        p  = px * py;
        return p[ACC_W-1:0];
    endfunction

    assign k_last    = k - KW'(1);
    assign k_bad     = (cfg_k == '0) || (cfg_k > KW'(K_MAX));
    assign a_final   = (a_row == MW'(TILE_M - 1)) && (a_col == k_last);
    assign b_final   = (b_row == k_last) && (b_col == NW'(TILE_N - 1));
    assign comp_last = (j == k_last);
    assign c_final   = (c_row == MW'(TILE_M - 1)) && (c_col == NW'(TILE_N - 1));
    assign a_col_i   = a_col[KI-1:0];
    assign b_row_i   = b_row[KI-1:0];
    assign j_i       = j[KI-1:0];

    assign m_axis_c_tdata = acc[c_row][c_col];
    assign err            = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        s_axis_a_tready = 1'b0;
        s_axis_b_tready = 1'b0;
        m_axis_c_tvalid = 1'b0;
        m_axis_c_tlast  = 1'b0;
        done            = 1'b0;
        busy            = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = k_bad ? DONE : LOAD_A;
                end
            end
            LOAD_A: begin
                s_axis_a_tready = 1'b1;
                if (s_axis_a_tvalid && a_final) begin
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                s_axis_b_tready = 1'b1;
                if (s_axis_b_tvalid && b_final) begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (comp_last) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                m_axis_c_tvalid = 1'b1;
                m_axis_c_tlast  = c_final;
                if (m_axis_c_tready && c_final) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counters, buffers, accumulators and the sticky error flag; beat count alone ends each load.
    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= '0;
            a_row <= '0;
            a_col <= '0;
            b_row <= '0;
            b_col <= '0;
            j     <= '0;
            c_row <= '0;
            c_col <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < TILE_M; i++) begin
                for (int n = 0; n < TILE_N; n++) begin
                    acc[i][n] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k     <= cfg_k;
                        err_q <= k_bad;
                        a_row <= '0;
                        a_col <= '0;
                        b_row <= '0;
                        b_col <= '0;
                        j     <= '0;
                        c_row <= '0;
                        c_col <= '0;
                        for (int i = 0; i < TILE_M; i++) begin
                            for (int n = 0; n < TILE_N; n++) begin
                                acc[i][n] <= '0;
                            end
                        end
                    end
                end
                LOAD_A: begin
                    if (s_axis_a_tvalid) begin
                        a_buf[a_row][a_col_i] <= s_axis_a_tdata;
                        if (s_axis_a_tlast != a_final) begin
                            err_q <= 1'b1;
                        end
                        if (a_col == k_last) begin
                            a_col <= '0;
                            a_row <= a_final ? '0 : a_row + MW'(1);
                        end else begin
                            a_col <= a_col + KW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (s_axis_b_tvalid) begin
                        b_buf[b_row_i][b_col] <= s_axis_b_tdata;
                        if (s_axis_b_tlast != b_final) begin
                            err_q <= 1'b1;
                        end
                        if (b_col == NW'(TILE_N - 1)) begin
                            b_col <= '0;
                            b_row <= b_final ? '0 : b_row + KW'(1);
                        end else begin
                            b_col <= b_col + NW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    for (int i = 0; i < TILE_M; i++) begin
                        for (int n = 0; n < TILE_N; n++) begin
                            acc[i][n] <= acc[i][n] + mac_term(a_buf[i][j_i], b_buf[j_i][n]);
                        end
                    end
                    j <= comp_last ? '0 : j + KW'(1);
                end
                OUTPUT: begin
                    if (m_axis_c_tready) begin
                        if (c_col == NW'(TILE_N - 1)) begin
                            c_col <= '0;
                            c_row <= c_final ? '0 : c_row + MW'(1);
                        end else begin
                            c_col <= c_col + NW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Self-checking bench for matmul_tile_engine: directed vector table, hand-written
// framing/reset sequences and randomized jobs against a plain-arithmetic reference model.
module tb_matmul_tile_engine;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 48;
    localparam int M      = 2;
    localparam int N      = 2;
    localparam int K_MAX  = 8;
    localparam int KW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] a_tdata, b_tdata;
    logic              a_tvalid, a_tready, a_tlast;
    logic              b_tvalid, b_tready, b_tlast;
    logic [ACC_W-1:0]  c_tdata;
    logic              c_tvalid, c_tready, c_tlast;
    logic [KW-1:0]     cfg_k;
    logic              start, busy, done, err;

    matmul_tile_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .TILE_M(M), .TILE_N(N), .K_MAX(K_MAX), .KW(KW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid),
        .s_axis_a_tready(a_tready), .s_axis_a_tlast(a_tlast),
        .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid),
        .s_axis_b_tready(b_tready), .s_axis_b_tlast(b_tlast),
        .m_axis_c_tdata(c_tdata), .m_axis_c_tvalid(c_tvalid),
        .m_axis_c_tready(c_tready), .m_axis_c_tlast(c_tlast),
        .cfg_k(cfg_k), .start(start), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW-1:0]               k;
        logic [15:0][DATA_W-1:0]     a;
        logic [15:0][DATA_W-1:0]     b;
        logic [3:0][ACC_W-1:0]       c;
        logic                        exp_err;
        logic [2:0]                  n_out;
    } vec_t;

    vec_t vecs [7];

    int n_cmp = 0;
    int n_bad = 0;

    int job_k;
    int job_a [16];
    int job_b [16];
    int early_beat;
    int gap_pct;
    int stall_pct;
    int rst_after;
    logic [ACC_W-1:0] exp_c [4];

    logic [ACC_W-1:0] got_c [$];
    bit               got_last [$];
    int  done_cnt, done_cyc, first_valid, stable_bad;
    bit  got_err, timed_out, saw_a_ready, saw_b_ready, post_done, post_busy;
    bit  rst_tvalid, rst_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: C[i][n] = sum_j A[i][j]*B[j][n], wrapped to ACC_W bits.
    function automatic void model();
        longint s;
        for (int i = 0; i < M; i++) begin
            for (int n = 0; n < N; n++) begin
                s = 0;
                for (int jj = 0; jj < job_k; jj++) begin
                    s += longint'(job_a[i*job_k+jj]) * longint'(job_b[jj*N+n]);
                end
                exp_c[i*N+n] = s[ACC_W-1:0];
            end
        end
    endfunction

    task automatic applyStimulus();
        int  a_idx, b_idx, na, nb, cyc;
        bit  kok, fin, prev_stall, pushed;
        logic [ACC_W-1:0] prev_data;
        logic prev_last;
        got_c.delete();
        got_last.delete();
        done_cnt = 0; done_cyc = -1; first_valid = -1; stable_bad = 0;
        got_err = 0; timed_out = 0; saw_a_ready = 0; saw_b_ready = 0;
        post_done = 0; post_busy = 0; rst_tvalid = 1; rst_busy = 1;
        kok = (job_k >= 1) && (job_k <= K_MAX);
        na = kok ? M * job_k : 0;
        nb = kok ? job_k * N : 0;
        a_idx = 0; b_idx = 0; cyc = 0; fin = 0; prev_stall = 0;
        prev_data = '0; prev_last = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_k = KW'(job_k);
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (a_tready) saw_a_ready = 1;
            if (b_tready) saw_b_ready = 1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                got_err = err;
            end
            if (!kok) begin
                a_tvalid = 1'b1; a_tdata = $urandom; a_tlast = 1'b0;
                b_tvalid = 1'b1; b_tdata = $urandom; b_tlast = 1'b0;
            end else begin
                if (a_idx < na) begin
                    a_tvalid = ($urandom_range(99) >= gap_pct);
                    a_tdata  = job_a[a_idx];
                    a_tlast  = (a_idx == na - 1) != (a_idx == early_beat);
                    if (a_tvalid && a_tready) a_idx++;
                end else begin
                    a_tvalid = 1'b0; a_tlast = 1'b0;
                end
                if (b_idx < nb) begin
                    b_tvalid = ($urandom_range(99) >= gap_pct);
                    b_tdata  = job_b[b_idx];
                    b_tlast  = (b_idx == nb - 1);
                    if (b_tvalid && b_tready) b_idx++;
                end else begin
                    b_tvalid = 1'b0; b_tlast = 1'b0;
                end
            end
            pushed = 0;
            if (c_tvalid) begin
                if (first_valid < 0) first_valid = cyc;
                if (prev_stall && ((c_tdata !== prev_data) || (c_tlast !== prev_last))) stable_bad++;
            end
            c_tready   = ($urandom_range(99) >= stall_pct);
            prev_stall = c_tvalid && !c_tready;
            prev_data  = c_tdata;
            prev_last  = c_tlast;
            if (c_tvalid && c_tready) begin
                got_c.push_back(c_tdata);
                got_last.push_back(c_tlast);
                pushed = 1;
            end
            if (pushed && (rst_after > 0) && (got_c.size() == rst_after)) begin
                @(negedge clk);
                rst = 1'b1;
                c_tready = 1'b0;
                @(negedge clk);
                rst_tvalid = c_tvalid;
                rst_busy   = busy;
                rst = 1'b0;
                fin = 1;
            end else if (done) begin
                fin = 1;
            end else if (cyc >= 600) begin
                timed_out = 1;
                fin = 1;
            end
        end
        a_tvalid = 1'b0; b_tvalid = 1'b0; a_tlast = 1'b0; b_tlast = 1'b0;
        if (rst_after <= 0) begin
            @(negedge clk);
            post_done = done;
            post_busy = busy;
            c_tready  = 1'b1;
            if (timed_out) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input bit exp_err, input int exp_n, input bit chk_lat);
        check("timeout", 64'(timed_out), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("err", 64'(got_err), 64'(exp_err));
        check("beat_count", 64'(got_c.size()), 64'(exp_n));
        for (int i = 0; i < got_c.size() && i < exp_n; i++) begin
            check("c_data", 64'(got_c[i]), 64'(exp_c[i]));
            check("c_last", 64'(got_last[i]), 64'(i == exp_n - 1));
        end
        check("c_stable", 64'(stable_bad), 64'd0);
        check("done_after", 64'(post_done), 64'd0);
        check("busy_after", 64'(post_busy), 64'd0);
        if (exp_n == 0) begin
            check("no_tready", 64'(saw_a_ready || saw_b_ready), 64'd0);
            check("done_cycle", 64'(done_cyc), 64'd1);
        end
        if (chk_lat) begin
            check("latency", 64'(first_valid), 64'(M * job_k + job_k * N + job_k + 1));
        end
    endtask

    task automatic load_vec(input int v);
        job_k = int'(vecs[v].k);
        for (int i = 0; i < 16; i++) begin
            job_a[i] = int'(vecs[v].a[i]);
            job_b[i] = int'(vecs[v].b[i]);
        end
        for (int i = 0; i < 4; i++) exp_c[i] = vecs[v].c[i];
        early_beat = -1; gap_pct = 0; stall_pct = 0; rst_after = -1;
    endtask

    initial begin
        vecs[0] = '0; vecs[0].k = 4'd2;
        vecs[0].a[0] = 1; vecs[0].a[1] = 2; vecs[0].a[2] = 3; vecs[0].a[3] = 4;
        vecs[0].b[0] = 5; vecs[0].b[1] = 6; vecs[0].b[2] = 7; vecs[0].b[3] = 8;
        vecs[0].c[0] = 19; vecs[0].c[1] = 22; vecs[0].c[2] = 43; vecs[0].c[3] = 50;
        vecs[0].n_out = 3'd4;

        vecs[1] = '0; vecs[1].k = 4'd8;
        vecs[1].a = {16{32'hFFFF_FFFF}};
        vecs[1].b = {16{32'd3}};
        vecs[1].c = {4{48'hFFFF_FFFF_FFE8}};
        vecs[1].n_out = 3'd4;

        vecs[2] = '0; vecs[2].k = 4'd1;
        vecs[2].a[0] = 2; vecs[2].a[1] = 32'hFFFF_FFFD;
        vecs[2].b[0] = 4; vecs[2].b[1] = 5;
        vecs[2].c[0] = 8; vecs[2].c[1] = 10;
        vecs[2].c[2] = 48'hFFFF_FFFF_FFF4; vecs[2].c[3] = 48'hFFFF_FFFF_FFF1;
        vecs[2].n_out = 3'd4;

        vecs[3] = '0; vecs[3].k = 4'd3;
        vecs[3].a[0] = 1; vecs[3].a[1] = 0; vecs[3].a[2] = 32'hFFFF_FFFF;
        vecs[3].a[3] = 2; vecs[3].a[4] = 1; vecs[3].a[5] = 0;
        vecs[3].b[0] = 1; vecs[3].b[1] = 2; vecs[3].b[2] = 3;
        vecs[3].b[3] = 4; vecs[3].b[4] = 5; vecs[3].b[5] = 6;
        vecs[3].c[0] = 48'hFFFF_FFFF_FFFC; vecs[3].c[1] = 48'hFFFF_FFFF_FFFC;
        vecs[3].c[2] = 5; vecs[3].c[3] = 8;
        vecs[3].n_out = 3'd4;

        vecs[4] = '0; vecs[4].k = 4'd1;
        vecs[4].a[0] = 32'h7FFF_FFFF; vecs[4].a[1] = 32'h8000_0000;
        vecs[4].b[0] = 32'h7FFF_FFFF; vecs[4].b[1] = 32'h8000_0000;
        vecs[4].c[0] = 48'hFFFF_0000_0001; vecs[4].c[1] = 48'h0000_8000_0000;
        vecs[4].c[2] = 48'h0000_8000_0000; vecs[4].c[3] = 48'h0;
        vecs[4].n_out = 3'd4;

        vecs[5] = '0; vecs[5].k = 4'd0; vecs[5].exp_err = 1'b1;
        vecs[6] = '0; vecs[6].k = 4'd9; vecs[6].exp_err = 1'b1;

        rst = 1'b1; start = 1'b0; cfg_k = '0;
        a_tdata = '0; a_tvalid = 1'b0; a_tlast = 1'b0;
        b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0;
        c_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_tready", 64'(a_tready), 64'd0);
        check("rst_b_tready", 64'(b_tready), 64'd0);
        check("rst_c_tvalid", 64'(c_tvalid), 64'd0);
        check("rst_c_tlast", 64'(c_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            applyStimulus();
            checkOutput(vecs[v].exp_err, int'(vecs[v].n_out), vecs[v].n_out != 0);
        end

        $display("[TB] early tlast on A beat 1");
        load_vec(0);
        early_beat = 1;
        applyStimulus();
        checkOutput(1'b1, 4, 1'b1);
        load_vec(0);
        applyStimulus();
        checkOutput(1'b0, 4, 1'b1);

        $display("[TB] reset during OUTPUT after two beats");
        load_vec(0);
        rst_after = 2;
        applyStimulus();
        check("rst_mid_beats", 64'(got_c.size()), 64'd2);
        for (int i = 0; i < got_c.size() && i < 2; i++) check("rst_mid_data", 64'(got_c[i]), 64'(exp_c[i]));
        check("rst_mid_tvalid", 64'(rst_tvalid), 64'd0);
        check("rst_mid_busy", 64'(rst_busy), 64'd0);
        c_tready = 1'b1;
        load_vec(3);
        applyStimulus();
        checkOutput(1'b0, 4, 1'b1);

        $display("[TB] randomized jobs with gaps and stalls");
        for (int t = 0; t < 12; t++) begin
            job_k = $urandom_range(K_MAX, 1);
            for (int i = 0; i < 16; i++) begin
                job_a[i] = (t % 2 == 0) ? int'($urandom_range(200)) - 100 : int'($urandom);
                job_b[i] = (t % 2 == 0) ? int'($urandom_range(200)) - 100 : int'($urandom);
            end
            early_beat = -1; rst_after = -1;
            gap_pct = 30; stall_pct = 40;
            model();
            applyStimulus();
            checkOutput(1'b0, 4, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
